// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - MULT/DIV unit sequencer with HI/LO load control and timeout
module muldiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start_mult,
  input  logic i_start_div,
  input  logic i_divisor_zero,
  input  logic i_abort,
  input  logic i_mult_done,
  input  logic i_div_done,
  output logic o_mult_init,
  output logic o_div_init,
  output logic o_hilo_sel,
  output logic o_hi_load,
  output logic o_lo_load,
  output logic o_busy,
  output logic o_done,
  output logic o_div_zero_exc,
  output logic o_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_M_INIT,
    S_M_WAIT,
    S_D_INIT,
    S_D_WAIT,
    S_WRITE,
    S_DZERO
  } state_t;

  // Last wait-cycle count before the operation is abandoned.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mult_init;
  logic             r_div_init;
  logic             r_hilo_sel;
  logic             r_load;
  logic             r_busy;
  logic             r_div_zero_exc;
  logic             r_timeout_err;

  // Completion flag of whichever unit the current wait state is listening to.
  logic w_unit_done;
  assign w_unit_done = (r_state == S_M_WAIT) ? i_mult_done : i_div_done;

  // Sequencer state, wait counter and registered Moore outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_mult_init    <= 1'b0;
      r_div_init     <= 1'b0;
      r_hilo_sel     <= 1'b0;
      r_load         <= 1'b0;
      r_busy         <= 1'b0;
      r_div_zero_exc <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      // Pulse outputs are one cycle wide unless a transition re-asserts them.
      r_mult_init    <= 1'b0;
      r_div_init     <= 1'b0;
      r_load         <= 1'b0;
      r_div_zero_exc <= 1'b0;
      r_timeout_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A flush in the same cycle as a request suppresses the request.
          if (!i_abort) begin
            if (i_start_mult) begin
              r_state     <= S_M_INIT;
              r_mult_init <= 1'b1;
              r_busy      <= 1'b1;
              r_hilo_sel  <= 1'b0;
            end else if (i_start_div && i_divisor_zero) begin
              r_state        <= S_DZERO;
              r_div_zero_exc <= 1'b1;
              r_busy         <= 1'b1;
            end else if (i_start_div) begin
              r_state    <= S_D_INIT;
              r_div_init <= 1'b1;
              r_busy     <= 1'b1;
              r_hilo_sel <= 1'b1;
            end
          end
        end
        S_M_INIT, S_D_INIT: begin
          r_cnt <= '0;
          if (i_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_hilo_sel <= 1'b0;
          end else begin
            r_state <= (r_state == S_M_INIT) ? S_M_WAIT : S_D_WAIT;
          end
        end
        S_M_WAIT, S_D_WAIT: begin
          if (i_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_hilo_sel <= 1'b0;
          end else if (w_unit_done) begin
            // hilo_sel keeps the value chosen at start so the load uses the right unit.
            r_state <= S_WRITE;
            r_load  <= 1'b1;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_hilo_sel    <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          // WRITE and DZERO last exactly one cycle.
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_hilo_sel <= 1'b0;
        end
      endcase
    end
  end

  assign o_mult_init    = r_mult_init;
  assign o_div_init     = r_div_init;
  assign o_hilo_sel     = r_hilo_sel;
  assign o_hi_load      = r_load;
  assign o_lo_load      = r_load;
  assign o_busy         = r_busy;
  assign o_done         = r_load;
  assign o_div_zero_exc = r_div_zero_exc;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam int K_NONE = 0;
  localparam int K_DONE = 1;
  localparam int K_DZ   = 2;
  localparam int K_TO   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_mult = 1'b0, start_div = 1'b0, divisor_zero = 1'b0, abort = 1'b0;
  logic mult_done = 1'b0, div_done = 1'b0;
  logic mult_init, div_init, hilo_sel, hi_load, lo_load, busy, done, div_zero_exc, timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.TIMEOUT(40), .CNT_W(6)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start_mult   (start_mult),
    .i_start_div    (start_div),
    .i_divisor_zero (divisor_zero),
    .i_abort        (abort),
    .i_mult_done    (mult_done),
    .i_div_done     (div_done),
    .o_mult_init    (mult_init),
    .o_div_init     (div_init),
    .o_hilo_sel     (hilo_sel),
    .o_hi_load      (hi_load),
    .o_lo_load      (lo_load),
    .o_busy         (busy),
    .o_done         (done),
    .o_div_zero_exc (div_zero_exc),
    .o_timeout_err  (timeout_err)
  );

  // Cycle numbers count from 1 = first cycle after the edge that samples the start.
  typedef struct {
    logic mult;
    logic div;
    logic dz;
    int   m_done;
    int   d_done;
    int   abort_c;
    int   restart_c;
    int   kind;
    logic sel;
    int   ev_cyc;
    int   busy_n;
    int   minit_n;
    int   dinit_n;
  } vec_t;

  typedef struct {
    int   kind;
    logic sel;
    int   cyc;
  } exp_t;

  vec_t tbl[11];
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   c, n_busy, n_mi, n_di, n_hi, n_lo, obs;
    bit   finished;
    exp_t e;
    @(posedge clk); #1;
    start_mult = v.mult; start_div = v.div; divisor_zero = v.dz;
    if (v.kind != K_NONE) begin
      e.kind = v.kind; e.sel = v.sel; e.cyc = v.ev_cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start_mult = 1'b0; start_div = 1'b0; divisor_zero = 1'b0;
    c = 1; n_busy = 0; n_mi = 0; n_di = 0; n_hi = 0; n_lo = 0; finished = 0;
    while (!finished && c <= 100) begin
      mult_done = (v.m_done == c);
      div_done  = (v.d_done == c);
      abort     = (v.abort_c == c);
      start_div = (v.restart_c == c);
      @(negedge clk);
      n_mi += int'(mult_init);
      n_di += int'(div_init);
      n_hi += int'(hi_load);
      n_lo += int'(lo_load);
      if (done || div_zero_exc || timeout_err) begin
        obs = done ? K_DONE : (div_zero_exc ? K_DZ : K_TO);
        if (sb.size() == 0) begin
          chk($sformatf("v%0d unexpected_event", idx), obs, K_NONE);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d event_kind", idx), obs, e.kind);
          chk($sformatf("v%0d event_cycle", idx), c, e.cyc);
          if (e.kind == K_DONE) chk($sformatf("v%0d hilo_sel_at_load", idx), int'(hilo_sel), int'(e.sel));
        end
      end
      if (busy) n_busy++;
      else finished = 1;
      @(posedge clk); #1;
      c++;
    end
    mult_done = 1'b0; div_done = 1'b0; abort = 1'b0; start_div = 1'b0;
    chk($sformatf("v%0d busy_bound", idx), int'(finished), 1);
    chk($sformatf("v%0d busy_cycles", idx), n_busy, v.busy_n);
    chk($sformatf("v%0d mult_init_cnt", idx), n_mi, v.minit_n);
    chk($sformatf("v%0d div_init_cnt", idx), n_di, v.dinit_n);
    chk($sformatf("v%0d hi_load_cnt", idx), n_hi, (v.kind == K_DONE) ? 1 : 0);
    chk($sformatf("v%0d lo_load_cnt", idx), n_lo, (v.kind == K_DONE) ? 1 : 0);
    chk($sformatf("v%0d missing_event", idx), sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    //            mul div dz mdn ddn abt rst kind    sel cyc busy mi di
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 34, 0,  0,  0, K_DONE, 1'b0, 35, 35, 1, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 0,  0,  0,  0, K_DZ,   1'b0, 1,  1,  0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 0,  0,  0,  0, K_TO,   1'b0, 42, 41, 0, 1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 0,  41, 0,  0, K_DONE, 1'b1, 42, 42, 0, 1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 0,  2,  0,  0, K_DONE, 1'b1, 3,  3,  0, 1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 5,  0,  0,  3, K_DONE, 1'b0, 6,  6,  1, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 10, 3,  0,  0, K_DONE, 1'b0, 11, 11, 1, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 0,  10, 10, 0, K_NONE, 1'b0, 0,  10, 0, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 0,  0,  0,  0, K_TO,   1'b0, 42, 41, 1, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 0,  0,  1,  0, K_NONE, 1'b0, 0,  1,  1, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4,  6,  0,  0, K_DONE, 1'b1, 7,  7,  0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({mult_init, div_init, hilo_sel, hi_load, lo_load, busy, done,
                               div_zero_exc, timeout_err}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_release_idle", int'(busy), 0);

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

    // Asynchronous reset in the middle of M_WAIT
    @(posedge clk); #1;
    start_mult = 1'b1;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({mult_init, div_init, hilo_sel, hi_load, lo_load, busy, done,
                                     div_zero_exc, timeout_err}), 0);
    @(posedge clk); #3;
    chk("held_reset_idle", int'(busy), 0);
    rst_n = 1'b1;
    #1;
    chk("release_no_change", int'(busy), 0);
    mult_done = 1'b1;
    @(negedge clk);
    chk("idle_after_release", int'({busy, done, hi_load}), 0);
    mult_done = 1'b0;

    // Normal operation resumes after reset
    run_vec(tbl[4], 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
